// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// Imported by the fetch buffer and the fetch unit top level.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [ADDR_W-1:0] PC_STEP_DEFAULT  = 16'd2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {instr, pc} queue: IR at the head plus one prefetch slot (PB).
// Flush empties the queue and overrides any push or pop in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    output logic               full
);

    buf_state_t         state, state_n;
    logic [INSTR_W-1:0] ir_n, pb, pb_n;
    logic [ADDR_W-1:0]  ir_pc_n, pb_pc, pb_pc_n;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            ir    <= '0;
            ir_pc <= '0;
            pb    <= '0;
            pb_pc <= '0;
        end else begin
            state <= state_n;
            ir    <= ir_n;
            ir_pc <= ir_pc_n;
            pb    <= pb_n;
            pb_pc <= pb_pc_n;
        end
    end

    // NOTE: every output of this block gets a hold default first, so no latch can be inferred.
    always_comb begin
        state_n = state;
        ir_n    = ir;
        ir_pc_n = ir_pc;
        pb_n    = pb;
        pb_pc_n = pb_pc;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        ir_n    = push_instr;
                        ir_pc_n = push_pc;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (pop && push) begin
                        ir_n    = push_instr;
                        ir_pc_n = push_pc;
                    end else if (pop) begin
                        state_n = EMPTY;
                    end else if (push) begin
                        pb_n    = push_instr;
                        pb_pc_n = push_pc;
                        state_n = TWO;
                    end
                end
                TWO: begin
                    // The prefetched entry always advances to the head on a pop.
                    if (pop) begin
                        ir_n    = pb;
                        ir_pc_n = pb_pc;
                        if (push) begin
                            pb_n    = push_instr;
                            pb_pc_n = push_pc;
                        end else begin
                            state_n = ONE;
                        end
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    assign ir_valid = (state != EMPTY);
    assign full     = (state == TWO);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, drives instruction memory and feeds the
// decode stage through a two-entry buffer; redirects flush and restart fetch.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               align_err,
    output logic [15:0]        fetch_count
);

    logic [ADDR_W-1:0] pc;
    logic              pop;
    logic              fetch;
    logic              full;

    assign pop   = ir_valid && ir_ready;
    // A full buffer can still accept a fetch when the head leaves in the same cycle.
    assign fetch = en && !redirect && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            align_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            align_err <= redirect && redirect_pc[0];
            if (redirect) begin
                pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
            end else if (fetch) begin
                pc <= pc + PC_STEP;
            end
            if (fetch) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

    assign imem_addr = pc;

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch),
        .pop        (pop),
        .flush      (redirect),
        .push_instr (imem_instr),
        .push_pc    (pc),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .full       (full)
    );

endmodule
